// File: rtl/ram_rd_check.sv
// Block-RAM read-back checker: sweeps addresses 0..DEPTH-1 and compares each
// returned word with (addr + SEED), counting mismatches and noting the first.
module ram_rd_check #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int SEED   = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err_flag,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                    state;
    logic [1:0]                    drain_cnt;
    logic [RD_LAT:1]               vld_pipe;
    logic [RD_LAT:1][ADDR_W-1:0]   addr_pipe;
    logic                          chk_v;
    logic [ADDR_W-1:0]             chk_addr;
    logic [DATA_W-1:0]             exp_data;
    logic                          mismatch;

    assign ram_en = (state == S_READ);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            ram_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_READ;
                        ram_addr <= '0;
                    end
                end
                S_READ: begin
                    if (ram_addr == ADDR_W'(DEPTH - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Leave once the last issued read has reached the compare stage.
                    if (drain_cnt == 2'(RD_LAT - 1)) state <= S_DONE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read request delayed to line up with the returned data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= ram_en;
            addr_pipe[1] <= ram_addr;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign chk_v    = vld_pipe[RD_LAT];
    assign chk_addr = addr_pipe[RD_LAT];
    assign exp_data = DATA_W'(32'(chk_addr) + 32'(SEED));
    assign mismatch = chk_v && (ram_rd_data != exp_data);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (state == S_IDLE && start) begin
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            err_flag <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!err_flag) first_err_addr <= chk_addr;
        end
    end

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: two instances (RD_LAT=1/SEED=0 and RD_LAT=2/SEED=3)
// each reading its own RAM model, checked against a per-sweep reference model.
module tb_ram_rd_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    always #5 clk = ~clk;

    logic       a_en, a_busy, a_done, a_flag;
    logic [4:0] a_addr, a_first;
    logic [5:0] a_cnt;
    logic [7:0] a_rd, a_q1;
    logic       b_en, b_busy, b_done, b_flag;
    logic [4:0] b_addr, b_first;
    logic [5:0] b_cnt;
    logic [7:0] b_rd, b_q1, b_q2;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];

    ram_rd_check u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .ram_en(a_en), .ram_addr(a_addr), .ram_rd_data(a_rd),
        .busy(a_busy), .done(a_done), .err_flag(a_flag),
        .err_cnt(a_cnt), .first_err_addr(a_first)
    );

    ram_rd_check #(.RD_LAT(2), .SEED(3)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .ram_en(b_en), .ram_addr(b_addr), .ram_rd_data(b_rd),
        .busy(b_busy), .done(b_done), .err_flag(b_flag),
        .err_cnt(b_cnt), .first_err_addr(b_first)
    );

    // Synchronous RAM models with 1- and 2-cycle read latency
    always @(posedge clk) begin
        a_q1 <= mem_a[a_addr];
        b_q1 <= mem_b[b_addr];
        b_q2 <= b_q1;
    end
    assign a_rd = a_q1;
    assign b_rd = b_q2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         a_dc = 0, b_dc = 0, a_dcyc, b_dcyc;
    logic       a_dflag, b_dflag;
    logic [5:0] a_dcnt, b_dcnt;
    logic [4:0] a_dfirst, b_dfirst;
    int         aq[$], bq[$];

    always @(negedge clk) begin
        if (a_en) aq.push_back(int'(a_addr));
        if (b_en) bq.push_back(int'(b_addr));
        if (a_done) begin
            a_dc++; a_dcyc = cyc; a_dflag = a_flag; a_dcnt = a_cnt; a_dfirst = a_first;
        end
        if (b_done) begin
            b_dc++; b_dcyc = cyc; b_dflag = b_flag; b_dcnt = b_cnt; b_dfirst = b_first;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: expected results from the sweep rule, independent of timing.
    task automatic model(input logic [7:0] m[32], input int seed,
                         output int flag, output int cnt, output int first);
        flag = 0; cnt = 0; first = 0;
        for (int k = 0; k < 32; k++) begin
            if (m[k] != 8'((k + seed) % 256)) begin
                if (flag == 0) first = k;
                flag = 1;
                cnt++;
            end
        end
        if (cnt > 63) cnt = 63;
    endtask

    task automatic sweep(input string tag, input int repulse_at);
        int e0, a0, b0, ok, bad, fl, cn, fi;
        a0 = a_dc; b0 = b_dc;
        aq.delete(); bq.delete();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
        chk({tag, "_clr_a"}, {a_busy, a_flag, a_cnt}, {1'b1, 7'd0});
        chk({tag, "_clr_b"}, {b_busy, b_flag, b_cnt}, {1'b1, 7'd0});
        if (repulse_at > 0) begin
            repeat (repulse_at) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_dc > a0 && b_dc > b0) begin ok = 1; break; end
        end
        chk({tag, "_finished"}, ok, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_once_a"}, a_dc - a0, 1);
        chk({tag, "_done_once_b"}, b_dc - b0, 1);
        chk({tag, "_idle"}, {a_busy, b_busy}, 0);
        chk({tag, "_lat_a"}, a_dcyc - e0 + 1, 34);
        chk({tag, "_lat_b"}, b_dcyc - e0 + 1, 35);
        bad = 0;
        for (int k = 0; k < aq.size(); k++) if (aq[k] != k) bad++;
        for (int k = 0; k < bq.size(); k++) if (bq[k] != k) bad++;
        chk({tag, "_addr_len"}, {aq.size(), bq.size()}, {32'd32, 32'd32});
        chk({tag, "_addr_seq"}, bad, 0);
        model(mem_a, 0, fl, cn, fi);
        chk({tag, "_a_done_res"}, {a_dflag, a_dcnt, a_dfirst}, {fl[0], cn[5:0], fi[4:0]});
        chk({tag, "_a_hold_res"}, {a_flag, a_cnt, a_first}, {fl[0], cn[5:0], fi[4:0]});
        model(mem_b, 3, fl, cn, fi);
        chk({tag, "_b_done_res"}, {b_dflag, b_dcnt, b_dfirst}, {fl[0], cn[5:0], fi[4:0]});
        chk({tag, "_b_hold_res"}, {b_flag, b_cnt, b_first}, {fl[0], cn[5:0], fi[4:0]});
    endtask

    task automatic fill_clean();
        for (int k = 0; k < 32; k++) begin
            mem_a[k] = 8'(k);
            mem_b[k] = 8'(k + 3);
        end
    endtask

    initial begin
        int ok, a0;
        fill_clean();
        #1;
        chk("rst_a", {a_en, a_addr, a_busy, a_done, a_flag, a_cnt, a_first}, 0);
        chk("rst_b", {b_en, b_addr, b_busy, b_done, b_flag, b_cnt, b_first}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {a_busy, b_busy, a_en, b_en}, 0);

        sweep("clean", 0);

        mem_a[5] = 8'hFF; mem_a[20] = 8'h00;
        mem_b[31] = mem_b[31] ^ 8'h01;
        sweep("two_err", 0);

        for (int k = 0; k < 32; k++) mem_a[k] = 8'hAA;
        mem_b[31] = 8'(31 + 3);
        sweep("all_aa", 0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 32; k++) begin
                mem_a[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(k);
                mem_b[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(k + 3);
            end
            sweep($sformatf("rand%0d", r), 0);
        end

        fill_clean();
        mem_a[7] = 8'h00;
        sweep("repulse", 6);
        fill_clean();
        sweep("after_repulse", 0);

        // Reset in the middle of a sweep
        mem_a[3] = 8'h55;
        a0 = a_dc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_en && a_addr == 5'd10) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("mid_reached_addr10", ok, 1);
        chk("mid_pre_rst_err", {a_flag, a_first}, {1'b1, 5'd3});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", {a_en, a_addr, a_busy, a_done, a_flag, a_cnt, a_first}, 0);
        chk("mid_rst_b", {b_en, b_addr, b_busy, b_done, b_flag, b_cnt, b_first}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("mid_no_done", a_dc - a0, 0);
        fill_clean();
        sweep("post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
- Read-back and verify side of the on-chip block-RAM test path. The `ip_ram` path writes a known pattern (data = address + SEED) into a single-port block RAM; this block is the matching reader.
- On `start`, it sweeps every address and compares each returned word against the expected pattern. It counts mismatches and records the first failing address.
- It sits beside the write controller, driving the RAM read port through a shared-port mux owned by the top level.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 32, number of words swept, addresses 0..DEPTH-1; DEPTH <= 2^ADDR_W.
- RD_LAT, 1, RAM read latency in cycles, 1..3.
- SEED, 0, pattern offset; expected(k) = (k + SEED) mod 2^DATA_W.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  level sampled in IDLE; high starts one sweep.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at end of sweep.
- err_flag  out  1  sticky; high if any mismatch in the last sweep.
- err_cnt  out  ADDR_W+1  mismatch count, saturating at all-ones.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - ram_en = 0, ram_addr = 0, busy = 0, done = 0.
  - err_flag = 0, err_cnt = 0, first_err_addr = 0.
  - Read-valid pipeline cleared.
  - Reset mid-sweep aborts the sweep: no done pulse, results cleared.
- States: IDLE, READ, DRAIN, DONE. busy = (state != IDLE).
- IDLE:
  - If start = 1 at edge E0: next state READ.
  - err_flag, err_cnt and first_err_addr clear at E0.
  - Results otherwise hold their values from the previous sweep.
- READ:
  - ram_en = 1; ram_addr = 0 in the first READ cycle, +1 each cycle.
  - Exactly DEPTH cycles (addresses 0..DEPTH-1), then DRAIN.
  - No wrap-around or repeated address.
- Read pipeline:
  - {ram_en, ram_addr} delayed by RD_LAT registers as {chk_v, chk_addr}.
  - In a cycle where chk_v = 1, ram_rd_data is compared with expected(chk_addr), computed in DATA_W bits with truncation.
  - Compare results are registered at the end of that cycle.
- Mismatch update:
  - err_flag <= 1.
  - err_cnt <= err_cnt + 1, unless err_cnt is all-ones.
  - first_err_addr <= chk_addr only if err_flag was 0 before this update.
- DRAIN:
  - ram_en = 0; ram_addr holds its last value.
  - Stays RD_LAT cycles, until the last compare is registered, then DONE.
- DONE:
  - done = 1 for exactly one cycle; result outputs are final and stable in this cycle.
  - Next state IDLE unconditionally.
- Latency: start sampled at edge E0 → done high in cycle DEPTH + RD_LAT + 1 after E0 (34 for the defaults).
- start while busy is ignored; no queueing. start held high continuously re-triggers a new sweep from the IDLE cycle after DONE.
- Simultaneous events: the last compare and the state move to DONE happen on the same edge; the DONE-cycle outputs include the last compare.

Test Plan:
- Defaults, RAM preloaded with mem[k] = k, start pulse 1 cycle → ram_en high 32 consecutive cycles, addresses 0..31; done pulses once 34 cycles after the start edge; err_flag = 0, err_cnt = 0, first_err_addr = 0.
- mem[5] = 8'hFF and mem[20] = 8'h00 (all others mem[k] = k) → err_flag = 1, err_cnt = 2, first_err_addr = 5 at done.
- RAM all 8'hAA (mem[k] ≠ k except at k = 0xAA, which is out of range) → err_cnt = 32 (no saturation at width 6); first_err_addr = 0.
- RD_LAT = 2, SEED = 3, mem[k] = k+3 → 0 errors. Then corrupt mem[31] → err_cnt = 1, first_err_addr = 31; done 35 cycles after the start edge.
- start re-pulsed during READ → ignored, single done; after done, a second start gives a clean sweep with results cleared at the new start edge.
- sys_rst_n pulled low at READ address 10 → all outputs 0 immediately; no done; after release, start produces a normal full sweep.
